qar_exec_checker: RTL and testbench



---
 rtl/qar_sim_pkg.sv | 19 +
 rtl/qar_sig_decode.sv | 19 +
 rtl/qar_exec_checker.sv | 128 ++++++++++++
 tb/tb_qar_exec_checker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qar_sim_pkg.sv
// Shared encodings for the qar_core execution checker: FSM states, fail codes
// and the TOHOST value that software writes to report success.
package qar_sim_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_PASS    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  localparam logic [2:0] FAIL_NONE     = 3'd0;
  localparam logic [2:0] FAIL_MISMATCH = 3'd1;
  localparam logic [2:0] FAIL_MISSING  = 3'd2;
  localparam logic [2:0] FAIL_TIMEOUT  = 3'd3;
  localparam logic [2:0] FAIL_SWFAIL   = 3'd4;

  localparam int TOHOST_PASS = 1;

endpackage

// File: rtl/qar_sig_decode.sv
// Combinational decode of a bus address into a signature-window hit and word index.
module qar_sig_decode #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] SIG_BASE   = 32'h0000_0010,
  parameter int                NUM_CHECKS = 4
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit,
  output logic [3:0]        o_index
);

  logic [ADDR_W-1:0] w_off;

  // Addresses below SIG_BASE wrap to large offsets and fall outside the window.
  assign w_off   = i_addr - SIG_BASE;
  assign o_hit   = (i_addr[1:0] == 2'b00) && (w_off < ADDR_W'(NUM_CHECKS * 4));
  assign o_index = w_off[5:2];

endmodule

// File: rtl/qar_exec_checker.sv
// Passive checker on the qar_core data bus: compares signature-window stores with
// expected values and reports pass/fail when software writes TOHOST or time runs out.
module qar_exec_checker
  import qar_sim_pkg::*;
#(
  parameter int                           ADDR_W         = 32,
  parameter int                           DATA_W         = 32,
  parameter int                           NUM_CHECKS     = 4,
  parameter logic [ADDR_W-1:0]            SIG_BASE       = 32'h0000_0010,
  parameter logic [ADDR_W-1:0]            TOHOST_ADDR    = 32'h0000_0100,
  parameter logic [NUM_CHECKS*DATA_W-1:0] EXP_VALUES     = '0,
  parameter int unsigned                  TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        fail_code,
  output logic [3:0]        fail_index,
  output logic [DATA_W-1:0] fail_value,
  output logic [15:0]       cycle_count
);

  logic [2:0]            r_state;
  logic [NUM_CHECKS-1:0] r_seen;
  logic [15:0]           r_cycles;
  logic [2:0]            r_fail_code;
  logic [3:0]            r_fail_index;
  logic [DATA_W-1:0]     r_fail_value;

  logic                  w_sig_hit;
  logic [3:0]            w_sig_idx;
  logic [DATA_W-1:0]     w_exp;
  logic [NUM_CHECKS-1:0] w_set;
  logic                  w_sig_st;
  logic                  w_host_st;
  logic                  w_at_limit;

  qar_sig_decode #(
    .ADDR_W     (ADDR_W),
    .SIG_BASE   (SIG_BASE),
    .NUM_CHECKS (NUM_CHECKS)
  ) u_decode (
    .i_addr  (mem_addr),
    .o_hit   (w_sig_hit),
    .o_index (w_sig_idx)
  );

  function automatic logic [3:0] lowest_unseen(input logic [NUM_CHECKS-1:0] seen);
    lowest_unseen = '0;
    for (int k = NUM_CHECKS - 1; k >= 0; k--) begin
      if (!seen[k]) lowest_unseen = 4'(k);
    end
  endfunction

  always_comb begin
    w_exp = '0;
    w_set = '0;
    for (int k = 0; k < NUM_CHECKS; k++) begin
      if (w_sig_idx == 4'(k)) begin
        w_exp    = EXP_VALUES[k*DATA_W +: DATA_W];
        w_set[k] = 1'b1;
      end
    end
  end

  assign w_sig_st   = mem_we && w_sig_hit;
  assign w_host_st  = mem_we && !w_sig_hit && (mem_addr == TOHOST_ADDR);
  assign w_at_limit = ({16'h0000, r_cycles} == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_seen       <= '0;
      r_cycles     <= '0;
      r_fail_code  <= FAIL_NONE;
      r_fail_index <= '0;
      r_fail_value <= '0;
    end else if (r_state == ST_RUN) begin
      if (r_cycles != 16'hFFFF) r_cycles <= r_cycles + 16'd1;
      if (w_sig_st) r_seen <= r_seen | w_set;
      // A terminating store in the final cycle takes precedence over timeout.
      if (w_sig_st && (mem_wdata != w_exp)) begin
        r_state      <= ST_FAIL;
        r_fail_code  <= FAIL_MISMATCH;
        r_fail_index <= w_sig_idx;
        r_fail_value <= mem_wdata;
      end else if (w_host_st) begin
        if (mem_wdata != DATA_W'(TOHOST_PASS)) begin
          r_state      <= ST_FAIL;
          r_fail_code  <= FAIL_SWFAIL;
          r_fail_value <= mem_wdata;
        end else if (&r_seen) begin
          r_state <= ST_PASS;
        end else begin
          r_state      <= ST_FAIL;
          r_fail_code  <= FAIL_MISSING;
          r_fail_index <= lowest_unseen(r_seen);
        end
      end else if (w_at_limit) begin
        r_state     <= ST_TIMEOUT;
        r_fail_code <= FAIL_TIMEOUT;
      end
    end else if (start) begin
      // Idle and terminal states restart identically.
      r_state      <= ST_RUN;
      r_seen       <= '0;
      r_cycles     <= '0;
      r_fail_code  <= FAIL_NONE;
      r_fail_index <= '0;
      r_fail_value <= '0;
    end
  end

  assign busy        = (r_state == ST_RUN);
  assign done        = (r_state == ST_PASS) || (r_state == ST_FAIL) || (r_state == ST_TIMEOUT);
  assign pass        = (r_state == ST_PASS);
  assign fail_code   = r_fail_code;
  assign fail_index  = r_fail_index;
  assign fail_value  = r_fail_value;
  assign cycle_count = r_cycles;

endmodule

// File: tb/tb_qar_exec_checker.sv
// Scoreboard bench for qar_exec_checker: directed and random runs against a
// store-list reference model; a monitor checks each completed run.
module tb_qar_exec_checker;

  localparam int          NC   = 2;
  localparam int          TO   = 8;
  localparam logic [31:0] SB   = 32'h0000_0010;
  localparam logic [31:0] TH   = 32'h0000_0100;
  localparam logic [63:0] EXPV = {32'd5, 32'd10};

  logic        clk = 1'b0;
  logic        rst, start, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        busy, done, pass;
  logic [2:0]  fail_code;
  logic [3:0]  fail_index;
  logic [31:0] fail_value;
  logic [15:0] cycle_count;

  always #5 clk = ~clk;

  qar_exec_checker #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .NUM_CHECKS     (NC),
    .SIG_BASE       (SB),
    .TOHOST_ADDR    (TH),
    .EXP_VALUES     (EXPV),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_code   (fail_code),
    .fail_index  (fail_index),
    .fail_value  (fail_value),
    .cycle_count (cycle_count)
  );

  typedef struct {
    bit          we;
    bit          st;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  typedef struct {
    bit          pass;
    logic [2:0]  code;
    logic [3:0]  idx;
    logic [31:0] val;
    logic [15:0] cyc;
    int          k;
  } exp_t;

  op_t  ops[$];
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    logic [63:0] v;
    v = EXPV;
    return v[i*32 +: 32];
  endfunction

  // Reference: walk the store list one RUN cycle at a time until a verdict.
  function automatic exp_t model();
    exp_t        e;
    bit          seen[NC];
    op_t         o;
    logic [31:0] a;
    e = '{pass: 1'b0, code: 3'd0, idx: 4'd0, val: 32'd0, cyc: 16'd0, k: 0};
    for (int i = 0; i < NC; i++) seen[i] = 1'b0;
    for (int k = 0; k < TO; k++) begin
      e.k   = k;
      e.cyc = 16'(k + 1);
      if (k < ops.size()) begin
        o = ops[k];
        a = o.addr;
        if (o.we && a[1:0] == 2'b00 && a >= SB && a < SB + 4 * NC) begin
          int i;
          i = int'((a - SB) / 4);
          seen[i] = 1'b1;
          if (o.data != exp_word(i)) begin
            e.code = 3'd1;
            e.idx  = 4'(i);
            e.val  = o.data;
            return e;
          end
        end else if (o.we && a == TH) begin
          if (o.data == 32'd1) begin
            int miss;
            miss = -1;
            for (int j = NC - 1; j >= 0; j--) if (!seen[j]) miss = j;
            if (miss < 0) e.pass = 1'b1;
            else begin
              e.code = 3'd2;
              e.idx  = 4'(miss);
            end
          end else begin
            e.code = 3'd4;
            e.val  = o.data;
          end
          return e;
        end
      end
    end
    e.code = 3'd3;
    return e;
  endfunction

  task automatic monitor();
    logic pd;
    exp_t e;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !pd) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL mon_unexpected_done: actual done=1 required no run pending");
        end else begin
          e = exp_q.pop_front();
          chk("mon_pass", pass, e.pass);
          chk("mon_code", fail_code, e.code);
          chk("mon_index", fail_index, e.idx);
          chk("mon_value", fail_value, e.val);
          chk("mon_cycles", cycle_count, e.cyc);
        end
      end
      pd = done;
    end
  endtask

  task automatic add(input bit we, input logic [31:0] a, input logic [31:0] d, input bit st);
    op_t o;
    o.we = we; o.st = st; o.addr = a; o.data = d;
    ops.push_back(o);
  endtask

  // Entered and left just after a falling edge.
  task automatic do_run(input string nm);
    exp_t e;
    op_t  o;
    e = model();
    exp_q.push_back(e);
    start = 1'b1;
    mem_we = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk({nm, "_clr_state"}, {busy, done, pass}, 3'b100);
    chk({nm, "_clr_cycles"}, cycle_count, 0);
    chk({nm, "_clr_fail"}, {fail_code, fail_index, fail_value}, 0);
    for (int k = 0; k <= e.k; k++) begin
      if (k < ops.size()) begin
        o = ops[k];
        mem_we = o.we; mem_addr = o.addr; mem_wdata = o.data; start = o.st;
      end else begin
        mem_we = 1'b0; start = 1'b0; mem_addr = $urandom; mem_wdata = $urandom;
      end
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      mem_we = 1'b0;
      if (k < e.k) chk({nm, "_running"}, {busy, done}, 2'b10);
      else         chk({nm, "_latency"}, {busy, done}, 2'b01);
    end
    // Further traffic after the verdict must not disturb it.
    mem_we = 1'b1; mem_addr = TH; mem_wdata = 32'd1;
    @(posedge clk); @(negedge clk);
    mem_addr = SB; mem_wdata = 32'hDEAD;
    @(posedge clk); @(negedge clk);
    mem_we = 1'b0;
    chk({nm, "_sticky_flags"}, {busy, done, pass}, {2'b01, e.pass});
    chk({nm, "_sticky_fail"}, {fail_code, fail_index, fail_value}, {e.code, e.idx, e.val});
    chk({nm, "_sticky_cycles"}, cycle_count, e.cyc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("reset_flags", {busy, done, pass}, 3'b000);
    chk("reset_fail", {fail_code, fail_index, fail_value}, 0);
    chk("reset_cycles", cycle_count, 0);
    rst = 1'b0;
    mem_we = 1'b1; mem_addr = TH; mem_wdata = 32'd1;
    @(posedge clk); @(negedge clk);
    mem_we = 1'b0;
    chk("idle_ignores_store", {busy, done, cycle_count}, 0);

    ops.delete(); add(1, SB, 10, 0); add(1, SB + 4, 5, 0); add(1, TH, 1, 0);
    do_run("happy");
    ops.delete(); add(1, SB, 7, 0);
    do_run("mismatch");
    ops.delete(); add(1, SB, 10, 0); add(1, TH, 1, 0);
    do_run("missing");
    ops.delete(); add(1, TH, 3, 0);
    do_run("swfail");
    ops.delete();
    do_run("timeout");
    ops.delete(); add(1, SB, 10, 0); add(1, SB + 4, 5, 0);
    repeat (5) add(0, TH, 1, 0);
    add(1, TH, 1, 0);
    do_run("tohost_at_limit");
    ops.delete(); add(1, SB + 2, 10, 0); add(1, SB + 8, 99, 0); add(0, SB, 10, 1);
    add(1, SB + 4, 5, 0); add(1, TH, 1, 0);
    do_run("ignored_traffic");
    ops.delete(); add(1, SB, 10, 0); add(1, SB + 4, 5, 0); add(1, TH, 1, 0);
    do_run("pass_first");
    do_run("pass_rerun");
    ops.delete(); add(1, SB, 10, 0); add(1, SB + 4, 6, 0);
    do_run("mismatch_idx1");

    // Reset in the middle of a run, with a mismatching store on the reset cycle.
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; mem_we = 1'b1; mem_addr = SB; mem_wdata = 32'd10;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; mem_addr = SB; mem_wdata = 32'd7;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; mem_we = 1'b0;
    chk("midrst_flags", {busy, done, pass}, 3'b000);
    chk("midrst_cycles", cycle_count, 0);
    chk("midrst_fail", {fail_code, fail_index, fail_value}, 0);
    repeat (3) @(negedge clk);
    chk("midrst_stays_idle", {busy, done, cycle_count}, 0);

    for (int r = 0; r < 24; r++) begin
      int n;
      ops.delete();
      n = $urandom_range(1, 9);
      for (int j = 0; j < n; j++) begin
        logic [31:0] a, d;
        case ($urandom_range(0, 7))
          0: a = SB;
          1: a = SB + 4;
          2: a = TH;
          3: a = SB + 2;
          4: a = SB + 8;
          5: a = SB - 4;
          6: a = TH + 1;
          default: a = $urandom & 32'h0000_01FC;
        endcase
        if (a == SB)          d = ($urandom_range(0, 4) != 0) ? 32'd10 : 32'($urandom_range(0, 15));
        else if (a == SB + 4) d = ($urandom_range(0, 4) != 0) ? 32'd5 : 32'($urandom_range(0, 15));
        else if (a == TH)     d = ($urandom_range(0, 3) != 0) ? 32'd1 : 32'($urandom_range(0, 15));
        else                  d = $urandom;
        add($urandom_range(0, 4) != 0, a, d, $urandom_range(0, 9) == 0);
      end
      do_run("random");
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
